eeprom_block_test: RTL and testbench
====================================

// Module: eeprom_block_test
// PURPOSE
//  Parametrised EEPROM self-test sequencer; next generation of the single-byte write/read LED test.
//  Writes NUM_BYTES of a generated pattern, waits the EEPROM write-cycle time after each byte,
//  reads all bytes back and compares them. Reports pass/fail, error count, first failing address and LEDs.
//  Sits between board top level and the iic_com I2C engine (Start/Addr/WrData/RdData/Done handshake).
// PARAMETERS
//  NUM_BYTES     16      bytes per test run, 1..256
//  BASE_ADDR     8'h00   first EEPROM word address
//  PATTERN_SEED  8'h12   data written to byte 0
//  PATTERN_STEP  8'h01   data increment per byte
//  WR_GAP_CYC    250000  idle clocks after each write Done (5 ms tWR @50 MHz); 0 = no gap
//  AUTO_START    1       1 = run once automatically after reset release
// PORTS
//  CLK_50M         in   1  system clock, 50 MHz
//  RSTn            in   1  asynchronous active-low reset
//  start           in   1  1-cycle pulse, begins a test run
//  iic_start       out  2  to iic_com Start_Sig: 2'b01 write, 2'b10 read, 2'b00 idle
//  iic_addr        out  8  to iic_com Addr_Sig
//  iic_wdata       out  8  to iic_com WrData
//  iic_rdata       in   8  from iic_com RdData
//  iic_done        in   1  from iic_com Done_Sig
//  busy            out  1  high while a run is in progress
//  done            out  1  1-cycle pulse at end of run
//  pass            out  1  run result, valid from done until next run starts
//  err_cnt         out  8  mismatching bytes, saturates at 255
//  first_err_addr  out  8  address of first mismatch; 0 if none
//  LED             out  4  [0]=busy [1]=pass [2]=fail [3]=toggles per completed byte transfer
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, byte index k=0; iic_start=00 immediately (async).
//  Byte k: addr = BASE_ADDR+k mod 256 (wraps FF->00); data = PATTERN_SEED+k*PATTERN_STEP mod 256.
//  FSM states: IDLE -> WR_REQ -> WR_GAP -> (next k: WR_REQ | last: RD_REQ) -> RD_REQ -> CMP -> (next k: RD_REQ | last: FINISH) -> IDLE.
//  IDLE: on start (or first cycle after reset if AUTO_START): clear err_cnt/first_err_addr/pass; busy=1; k=0.
//  WR_REQ: drive iic_start=01 with iic_addr/iic_wdata stable until iic_done=1.
//   The cycle after iic_done=1: iic_start=00 and LED[3] toggles.
//  WR_GAP: count WR_GAP_CYC clocks with iic_start=00. Then k+1, or k=0 and go to RD_REQ after the last byte.
//  RD_REQ: drive iic_start=10 until iic_done=1. iic_rdata is sampled on the iic_done=1 cycle.
//   The next cycle: iic_start=00.
//  CMP (1 cycle): on mismatch, err_cnt+1 (saturating); first_err_addr is set only on the first mismatch.
//  Handshake rule: at least one iic_start=00 cycle between any two requests. Request fields never change while iic_start!=00.
//  FINISH: busy=0, done=1 for exactly one cycle, pass=(err_cnt==0); LED[1]=pass, LED[2]=!pass; both held until next start.
//  start while busy: ignored. start in IDLE after a run: restarts and clears results/LED[2:1].
//  iic_done while iic_start=00: ignored.
//  NUM_BYTES=1: one write, one gap, one read. Reset mid-run aborts immediately; iic_com shares RSTn.
// TESTING (bench uses behavioural iic_com model: 256-byte memory, Done 1 cycle high, 10 cycles after request)
//  1. AUTO_START=1, NUM_BYTES=4, WR_GAP_CYC=20 -> writes 00:12,01:13,02:14,03:15 then 4 reads;
//     done pulse 1 cycle, pass=1, err_cnt=0, LED[2:0]=3'b010.
//  2. Model corrupts read of addr 02 (returns 8'h00) -> err_cnt=1, first_err_addr=8'h02, pass=0, LED[2:1]=2'b10.
//  3. BASE_ADDR=8'hFE, NUM_BYTES=4 -> iic_addr sequence FE,FF,00,01 for writes and for reads; pass=1.
//  4. WR_GAP_CYC=100 -> >=100 cycles from each write iic_done to next iic_start!=00; always >=1 idle cycle between requests.
//  5. RSTn low for 3 cycles during RD_REQ -> iic_start=00, busy=0, err_cnt=0 asynchronously;
//     after release, AUTO_START rerun begins at byte 0 and passes.
//  6. AUTO_START=0: start pulse while busy has no effect. Second start after done -> full rerun, results cleared, single done pulse.

Source files
------------

// File: rtl/eeprom_block_test.sv
// EEPROM self-test sequencer: writes a generated byte pattern through iic_com, waits tWR after
// each write, reads the block back and reports pass/fail, error count and first failing address.
module eeprom_block_test #(
  parameter int         NUM_BYTES    = 16,
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter logic [7:0] PATTERN_SEED = 8'h12,
  parameter logic [7:0] PATTERN_STEP = 8'h01,
  parameter int         WR_GAP_CYC   = 250000,
  parameter bit         AUTO_START   = 1'b1
) (
  input  logic       CLK_50M,
  input  logic       RSTn,
  input  logic       start,
  output logic [1:0] iic_start,
  output logic [7:0] iic_addr,
  output logic [7:0] iic_wdata,
  input  logic [7:0] iic_rdata,
  input  logic       iic_done,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] first_err_addr,
  output logic [3:0] LED
);

  localparam int               GAP_W    = (WR_GAP_CYC < 2) ? 1 : $clog2(WR_GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((WR_GAP_CYC > 0) ? WR_GAP_CYC - 1 : 0);
  localparam logic [7:0]       LAST_K   = 8'(NUM_BYTES - 1);
  localparam logic [1:0]       REQ_IDLE = 2'b00;
  localparam logic [1:0]       REQ_WR   = 2'b01;
  localparam logic [1:0]       REQ_RD   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_CMP, S_FINISH
  } state_t;

  state_t           r_state;
  logic [1:0]       r_iic_start;
  logic [7:0]       r_k;
  logic [7:0]       r_addr;
  logic [7:0]       r_wdata;
  logic [7:0]       r_exp;
  logic [7:0]       r_rdata;
  logic [7:0]       r_err_cnt;
  logic [7:0]       r_first_err_addr;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_led_tog;
  logic             r_auto_pend;

  logic w_go;
  logic w_last;
  logic w_mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign w_go       = start || r_auto_pend;
  assign w_last     = (r_k == LAST_K);
  assign w_mismatch = (r_rdata != r_exp);

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      r_state          <= S_IDLE;
      r_iic_start      <= REQ_IDLE;
      r_k              <= '0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_exp            <= '0;
      r_rdata          <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_gap_cnt        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail           <= 1'b0;
      r_led_tog        <= 1'b0;
      r_auto_pend      <= AUTO_START;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_auto_pend      <= 1'b0;
            r_busy           <= 1'b1;
            r_pass           <= 1'b0;
            r_fail           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_k              <= '0;
            r_addr           <= BASE_ADDR;
            r_wdata          <= PATTERN_SEED;
            r_iic_start      <= REQ_WR;
            r_state          <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (iic_done) begin
            r_iic_start <= REQ_IDLE;
            r_led_tog   <= ~r_led_tog;
            r_gap_cnt   <= '0;
            r_state     <= S_WR_GAP;
          end
        end
        // The gap state always lasts at least one cycle, so requests never abut.
        S_WR_GAP: begin
          if (WR_GAP_CYC == 0 || r_gap_cnt == GAP_LAST) begin
            if (w_last) begin
              r_k         <= '0;
              r_addr      <= BASE_ADDR;
              r_exp       <= PATTERN_SEED;
              r_iic_start <= REQ_RD;
              r_state     <= S_RD_REQ;
            end else begin
              r_k         <= r_k + 8'd1;
              r_addr      <= r_addr + 8'd1;
              r_wdata     <= r_wdata + PATTERN_STEP;
              r_iic_start <= REQ_WR;
              r_state     <= S_WR_REQ;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        S_RD_REQ: begin
          if (iic_done) begin
            r_rdata     <= iic_rdata;
            r_iic_start <= REQ_IDLE;
            r_led_tog   <= ~r_led_tog;
            r_state     <= S_CMP;
          end
        end
        S_CMP: begin
          if (w_mismatch) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            if (r_err_cnt == 8'd0) r_first_err_addr <= r_addr;
          end
          if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_k         <= r_k + 8'd1;
            r_addr      <= r_addr + 8'd1;
            r_exp       <= r_exp + PATTERN_STEP;
            r_iic_start <= REQ_RD;
            r_state     <= S_RD_REQ;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == 8'd0);
          r_fail  <= (r_err_cnt != 8'd0);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign iic_start      = r_iic_start;
  assign iic_addr       = r_addr;
  assign iic_wdata      = r_wdata;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;
  assign LED            = {r_led_tog, r_fail, r_pass, r_busy};

endmodule

// File: tb/tb_eeprom_block_test.sv
// Bench for eeprom_block_test: three sequencer instances against a behavioural iic_com model,
// with an expected-request scoreboard and directed result checks.
module tb_eeprom_block_test;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rstn  [3];
  logic       stt   [3];
  logic [1:0] s_st  [3];
  logic [7:0] s_ad  [3];
  logic [7:0] s_wd  [3];
  logic [7:0] m_rd  [3];
  logic       m_dn  [3];
  logic       s_busy[3];
  logic       s_done[3];
  logic       s_pass[3];
  logic [7:0] s_err [3];
  logic [7:0] s_fea [3];
  logic [3:0] s_led [3];
  logic       corrupt;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];

  eeprom_block_test #(.NUM_BYTES(4), .BASE_ADDR(8'h00), .PATTERN_SEED(8'h12), .PATTERN_STEP(8'h01),
                      .WR_GAP_CYC(20), .AUTO_START(1'b1)) u_dut0 (
    .CLK_50M(clk), .RSTn(rstn[0]), .start(stt[0]), .iic_start(s_st[0]), .iic_addr(s_ad[0]),
    .iic_wdata(s_wd[0]), .iic_rdata(m_rd[0]), .iic_done(m_dn[0]), .busy(s_busy[0]), .done(s_done[0]),
    .pass(s_pass[0]), .err_cnt(s_err[0]), .first_err_addr(s_fea[0]), .LED(s_led[0]));

  eeprom_block_test #(.NUM_BYTES(4), .BASE_ADDR(8'hFE), .PATTERN_SEED(8'h40), .PATTERN_STEP(8'h03),
                      .WR_GAP_CYC(100), .AUTO_START(1'b1)) u_dut1 (
    .CLK_50M(clk), .RSTn(rstn[1]), .start(stt[1]), .iic_start(s_st[1]), .iic_addr(s_ad[1]),
    .iic_wdata(s_wd[1]), .iic_rdata(m_rd[1]), .iic_done(m_dn[1]), .busy(s_busy[1]), .done(s_done[1]),
    .pass(s_pass[1]), .err_cnt(s_err[1]), .first_err_addr(s_fea[1]), .LED(s_led[1]));

  eeprom_block_test #(.NUM_BYTES(1), .BASE_ADDR(8'h10), .PATTERN_SEED(8'hA5), .PATTERN_STEP(8'h01),
                      .WR_GAP_CYC(0), .AUTO_START(1'b0)) u_dut2 (
    .CLK_50M(clk), .RSTn(rstn[2]), .start(stt[2]), .iic_start(s_st[2]), .iic_addr(s_ad[2]),
    .iic_wdata(s_wd[2]), .iic_rdata(m_rd[2]), .iic_done(m_dn[2]), .busy(s_busy[2]), .done(s_done[2]),
    .pass(s_pass[2]), .err_cnt(s_err[2]), .first_err_addr(s_fea[2]), .LED(s_led[2]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 20 : (i == 1) ? 100 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  // iic_com model: Done pulses 10 cycles after a request appears; addr 02 reads back 00 when corrupt.
  logic [7:0] mem [3][256];
  int         m_cnt [3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_dn[i] <= 1'b0;
      if (!rstn[i]) begin
        m_cnt[i] <= 0;
      end else if (s_st[i] != 2'b00 && !m_dn[i]) begin
        if (m_cnt[i] == 9) begin
          m_dn[i]  <= 1'b1;
          m_cnt[i] <= 0;
          if (s_st[i] == 2'b01) mem[i][s_ad[i]] <= s_wd[i];
          else m_rd[i] <= (corrupt && i == 0 && s_ad[i] == 8'h02) ? 8'h00 : mem[i][s_ad[i]];
        end else begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
      end else begin
        m_cnt[i] <= 0;
      end
    end
  end

  logic [1:0] prev_st[3] = '{2'b00, 2'b00, 2'b00};
  logic [1:0] lat_st [3];
  logic [7:0] lat_ad [3];
  logic [7:0] lat_wd [3];
  int         idle   [3] = '{0, 0, 0};
  logic       last_wr[3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    logic [31:0] o_v, e_v;
    int need;
    for (int i = 0; i < 3; i++) begin
      if (s_st[i] != 2'b00 && prev_st[i] == 2'b00) begin
        o_v = {8'(i), 6'd0, s_st[i], s_ad[i], (s_st[i] == 2'b01) ? s_wd[i] : 8'h00};
        check("sb_pending", 32'(exp_q.size() > 0), 1);
        e_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("sb_request", o_v, e_v);
        need = (last_wr[i] && gap_of(i) > 1) ? gap_of(i) : 1;
        check("req_spacing", 32'(idle[i] >= need), 1);
        lat_st[i] <= s_st[i];
        lat_ad[i] <= s_ad[i];
        lat_wd[i] <= s_wd[i];
      end
      if (s_st[i] != 2'b00 && m_dn[i]) begin
        check("req_stable", {14'h0, s_st[i], s_ad[i], s_wd[i]}, {14'h0, lat_st[i], lat_ad[i], lat_wd[i]});
        last_wr[i] <= (s_st[i] == 2'b01);
      end
      if (!rstn[i]) last_wr[i] <= 1'b0;
      idle[i]    <= (s_st[i] == 2'b00) ? idle[i] + 1 : 0;
      prev_st[i] <= s_st[i];
    end
  end

  task automatic push_run(input int i, input logic [7:0] base, input logic [7:0] seed,
                          input logic [7:0] step, input int nb);
    for (int k = 0; k < nb; k++)
      exp_q.push_back({8'(i), 8'h01, 8'(base + k), 8'(seed + k * step)});
    for (int k = 0; k < nb; k++)
      exp_q.push_back({8'(i), 8'h02, 8'(base + k), 8'h00});
  endtask

  task automatic pulse(input int i);
    @(negedge clk);
    stt[i] = 1'b1;
    @(negedge clk);
    stt[i] = 1'b0;
  endtask

  task automatic finish_run(input int i, input int budget, input string pfx, input logic e_pass,
                            input logic [7:0] e_err, input logic [7:0] e_fea, input logic [3:0] e_led);
    int n = 0;
    while (!s_done[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({pfx, "_done_seen"}, s_done[i], 1);
    check({pfx, "_result"}, {s_pass[i], s_err[i], s_fea[i]}, {e_pass, e_err, e_fea});
    check({pfx, "_led"}, s_led[i], e_led);
    check({pfx, "_busy_low"}, s_busy[i], 0);
    @(negedge clk);
    check({pfx, "_done_width"}, s_done[i], 0);
    check({pfx, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0;
      stt[i]  = 1'b0;
    end
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("reset_outputs", {s_st[i], s_busy[i], s_done[i], s_pass[i], s_err[i], s_fea[i], s_led[i]}, 0);

    // Auto-started clean run on instance 0.
    push_run(0, 8'h00, 8'h12, 8'h01, 4);
    rstn[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_busy", {s_busy[0], s_led[0][0]}, 2'b11);
    n = 0;
    while (!m_dn[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_first_wr_done", m_dn[0], 1);
    @(negedge clk);
    check("t1_led3_toggle", s_led[0][3], 1);
    check("t1_req_released", s_st[0], 0);
    finish_run(0, 1000, "t1", 1'b1, 8'h00, 8'h00, 4'b0010);

    // Corrupted readback of address 02.
    corrupt = 1'b1;
    push_run(0, 8'h00, 8'h12, 8'h01, 4);
    pulse(0);
    check("t2_results_cleared", {s_busy[0], s_pass[0], s_led[0][2:1]}, 4'b1000);
    finish_run(0, 1000, "t2", 1'b0, 8'h01, 8'h02, 4'b0100);

    // Reset during the last read, then auto-start rerun.
    push_run(0, 8'h00, 8'h12, 8'h01, 4);
    pulse(0);
    n = 0;
    while (!(s_st[0] == 2'b10 && s_err[0] == 8'd1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_rd_req", {s_st[0], s_err[0]}, {2'b10, 8'h01});
    rstn[0] = 1'b0;
    #1;
    check("t5_async_reset", {s_st[0], s_busy[0], s_err[0]}, 0);
    repeat (3) @(negedge clk);
    corrupt = 1'b0;
    exp_q.delete();
    push_run(0, 8'h00, 8'h12, 8'h01, 4);
    rstn[0] = 1'b1;
    finish_run(0, 1000, "t5", 1'b1, 8'h00, 8'h00, 4'b0010);

    // Address wrap FE..01 and 100-cycle write gap on instance 1.
    push_run(1, 8'hFE, 8'h40, 8'h03, 4);
    rstn[1] = 1'b1;
    finish_run(1, 2000, "t3", 1'b1, 8'h00, 8'h00, 4'b0010);

    // Manual start, single byte, zero gap on instance 2.
    rstn[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_autostart", {s_busy[2], s_st[2]}, 0);
    push_run(2, 8'h10, 8'hA5, 8'h01, 1);
    pulse(2);
    check("t6_busy", s_busy[2], 1);
    n = 0;
    while (s_st[2] != 2'b10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_rd_req", s_st[2], 2'b10);
    pulse(2);
    finish_run(2, 500, "t6a", 1'b1, 8'h00, 8'h00, 4'b0010);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_done[2]) n++;
    end
    check("t6a_no_extra_done", n, 0);
    push_run(2, 8'h10, 8'hA5, 8'h01, 1);
    pulse(2);
    check("t6b_results_cleared", {s_busy[2], s_pass[2], s_led[2][2:1]}, 4'b1000);
    finish_run(2, 500, "t6b", 1'b1, 8'h00, 8'h00, 4'b0010);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_done[2]) n++;
    end
    check("t6b_no_extra_done", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
